// File: rtl/pong_game_ctrl.sv
// Frame-synchronous Pong controller: owns paddle, ball and score registers.
// An accepted frame_tick runs one paddle cycle, then one ball cycle against the new paddles.
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 50,
  parameter int BALL_SIZE    = 7,
  parameter int P1_X         = 0,
  parameter int P2_X         = 630,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [2:0] state,
  output logic [1:0] winner,
  output logic       busy
);

  localparam logic [10:0] PAD_SPD = 11'(PADDLE_SPEED);
  localparam logic [10:0] PAD_MAX = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] PAD_H   = 11'(PADDLE_H);
  localparam logic [10:0] B_SZ    = 11'(BALL_SIZE);
  localparam logic [10:0] B_SPD   = 11'(BALL_SPEED);
  localparam logic [10:0] Y_MAX   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] X_MAX   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] P2_EDGE = 11'(P2_X);
  localparam logic [10:0] P1_EDGE = 11'(P1_X + PADDLE_W);
  localparam logic [9:0]  BALL_X0 = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  BALL_Y0 = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]  PAD_Y0  = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [3:0]  WIN_S   = 4'(WIN_SCORE);
  localparam int          CNT_W   = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_PAD  = 2'd1,
    PH_BALL = 2'd2
  } phase_e;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic             busy_q, busy_d;
  logic [9:0]       p1_y_q, p1_y_d;
  logic [9:0]       p2_y_q, p2_y_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic             dir_x_q, dir_x_d;   // 1 = moving right
  logic             dir_y_q, dir_y_d;   // 1 = moving down
  logic [3:0]       score_p1_q, score_p1_d;
  logic [3:0]       score_p2_q, score_p2_d;
  logic [1:0]       winner_q, winner_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             p1_scored_q, p1_scored_d;

  logic [10:0] bx;
  logic [10:0] by;
  logic [3:0]  new_score;

  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up,
                                          input logic dn);
    logic [10:0] y11;
    y11      = {1'b0, y};
    pad_step = y;
    if (up && !dn) begin
      pad_step = (y11 >= PAD_SPD) ? 10'(y11 - PAD_SPD) : 10'd0;
    end else if (dn && !up) begin
      pad_step = (y11 + PAD_SPD > PAD_MAX) ? 10'(PAD_MAX) : 10'(y11 + PAD_SPD);
    end
  endfunction

  function automatic logic overlap(input logic [10:0] ball_top, input logic [9:0] pad_top);
    logic [10:0] py;
    py      = {1'b0, pad_top};
    overlap = (ball_top + B_SZ > py) && (ball_top < py + PAD_H);
  endfunction

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    score_inc = (s >= WIN_S) ? s : s + 4'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    p1_y_d      = p1_y_q;
    p2_y_d      = p2_y_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    winner_d    = winner_q;
    frame_cnt_d = frame_cnt_q;
    p1_scored_d = p1_scored_q;
    bx          = {1'b0, ball_x_q};
    by          = {1'b0, ball_y_q};
    new_score   = 4'd0;

    if (phase_q == PH_PAD) begin
      p1_y_d  = pad_step(p1_y_q, p1_up, p1_dn);
      p2_y_d  = pad_step(p2_y_q, p2_up, p2_dn);
      phase_d = PH_BALL;
    end else if (phase_q == PH_BALL) begin
      phase_d = PH_IDLE;
      if (state_q == ST_SERVE) begin
        if (frame_cnt_q == CNT_LAST) begin
          state_d     = ST_PLAY;
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end else if (state_q == ST_PLAY) begin
        if (dir_y_q) begin
          if (by + B_SPD >= Y_MAX) begin
            ball_y_d = 10'(Y_MAX);
            dir_y_d  = 1'b0;
          end else begin
            ball_y_d = 10'(by + B_SPD);
          end
        end else begin
          if (by < B_SPD) begin
            ball_y_d = 10'd0;
            dir_y_d  = 1'b1;
          end else begin
            ball_y_d = 10'(by - B_SPD);
          end
        end
        // Paddle hits use the paddle positions written in the preceding cycle.
        if (dir_x_q) begin
          if ((bx + B_SZ + B_SPD >= P2_EDGE) && overlap(by, p2_y_q)) begin
            ball_x_d = 10'(P2_EDGE - B_SZ);
            dir_x_d  = 1'b0;
          end else if (bx + B_SPD > X_MAX) begin
            p1_scored_d = 1'b1;
            state_d     = ST_POINT;
          end else begin
            ball_x_d = 10'(bx + B_SPD);
          end
        end else begin
          if ((bx <= P1_EDGE + B_SPD) && overlap(by, p1_y_q)) begin
            ball_x_d = 10'(P1_EDGE);
            dir_x_d  = 1'b1;
          end else if (bx < B_SPD) begin
            p1_scored_d = 1'b0;
            state_d     = ST_POINT;
          end else begin
            ball_x_d = 10'(bx - B_SPD);
          end
        end
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_d     = ST_SERVE;
            score_p1_d  = 4'd0;
            score_p2_d  = 4'd0;
            winner_d    = 2'd0;
            p1_y_d      = PAD_Y0;
            p2_y_d      = PAD_Y0;
            ball_x_d    = BALL_X0;
            ball_y_d    = BALL_Y0;
            dir_x_d     = 1'b1;
            dir_y_d     = 1'b1;
            frame_cnt_d = '0;
          end
        end
        ST_SERVE, ST_PLAY: begin
          if (frame_tick) begin
            phase_d = PH_PAD;
          end
        end
        ST_POINT: begin
          new_score = score_inc(p1_scored_q ? score_p1_q : score_p2_q);
          if (p1_scored_q) begin
            score_p1_d = new_score;
          end else begin
            score_p2_d = new_score;
          end
          if (new_score == WIN_S) begin
            winner_d = p1_scored_q ? 2'd1 : 2'd2;
            state_d  = ST_OVER;
          end else begin
            // Serve toward the player who just conceded.
            ball_x_d    = BALL_X0;
            ball_y_d    = BALL_Y0;
            dir_x_d     = p1_scored_q;
            frame_cnt_d = '0;
            state_d     = ST_SERVE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (phase_d != PH_IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_IDLE;
      busy_q      <= 1'b0;
      p1_y_q      <= PAD_Y0;
      p2_y_q      <= PAD_Y0;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      score_p1_q  <= 4'd0;
      score_p2_q  <= 4'd0;
      winner_q    <= 2'd0;
      frame_cnt_q <= '0;
      p1_scored_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      p1_y_q      <= p1_y_d;
      p2_y_q      <= p2_y_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      winner_q    <= winner_d;
      frame_cnt_q <= frame_cnt_d;
      p1_scored_q <= p1_scored_d;
    end
  end

  assign p1_y     = p1_y_q;
  assign p2_y     = p2_y_q;
  assign ball_x   = ball_x_q;
  assign ball_y   = ball_y_q;
  assign score_p1 = score_p1_q;
  assign score_p2 = score_p2_q;
  assign state    = state_q;
  assign winner   = winner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: per-frame game model plus directed play with simple paddle AIs.
module tb_pong_game_ctrl;

  localparam int SW = 640, SH = 480, PW = 10, PH = 50, BSZ = 7;
  localparam int P1X = 0, P2X = 630, PSPD = 4, BSPD = 2, SERVE_N = 60, WIN = 9;
  localparam int IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0;
  logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic [9:0] p1_y, p2_y, ball_x, ball_y;
  logic [3:0] score_p1, score_p2;
  logic [2:0] state;
  logic [1:0] winner;
  logic       busy;

  int checks = 0, errors = 0;
  bit chk_en = 1'b1;
  bit seen_point = 1'b0;

  int m_state, m_p1, m_p2, m_bx, m_by, m_dx, m_dy;
  int m_s1, m_s2, m_win, m_serve, m_age, m_scorer;

  pong_game_ctrl dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .frame_tick(frame_tick),
    .start     (start),
    .p1_up     (p1_up),
    .p1_dn     (p1_dn),
    .p2_up     (p2_up),
    .p2_dn     (p2_dn),
    .p1_y      (p1_y),
    .p2_y      (p2_y),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .score_p1  (score_p1),
    .score_p2  (score_p2),
    .state     (state),
    .winner    (winner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int paddle_next(input int y, input logic up, input logic dn);
    if (up && !dn) return (y >= PSPD) ? y - PSPD : 0;
    if (dn && !up) return (y + PSPD > SH - PH) ? SH - PH : y + PSPD;
    return y;
  endfunction

  function automatic bit overlaps(input int by, input int py);
    return (by + BSZ > py) && (by < py + PH);
  endfunction

  task automatic model_centre_ball();
    m_bx = (SW - BSZ) / 2;
    m_by = (SH - BSZ) / 2;
  endtask

  task automatic model_reset();
    m_state = IDLE; m_p1 = (SH - PH) / 2; m_p2 = (SH - PH) / 2;
    model_centre_ball();
    m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_win = 0;
    m_serve = 0; m_age = 0; m_scorer = 0;
  endtask

  task automatic model_new_game();
    m_state = SERVE; m_s1 = 0; m_s2 = 0; m_win = 0; m_serve = 0;
    m_p1 = (SH - PH) / 2; m_p2 = (SH - PH) / 2;
    model_centre_ball();
    m_dx = 1; m_dy = 1;
  endtask

  task automatic model_ball();
    int nx, ny, ndx, ndy;
    nx = m_bx; ny = m_by; ndx = m_dx; ndy = m_dy;
    if (m_dy > 0) begin
      if (m_by + BSPD >= SH - BSZ) begin ny = SH - BSZ; ndy = -1; end
      else ny = m_by + BSPD;
    end else begin
      if (m_by < BSPD) begin ny = 0; ndy = 1; end
      else ny = m_by - BSPD;
    end
    if (m_dx > 0) begin
      if (m_bx + BSZ + BSPD >= P2X && overlaps(m_by, m_p2)) begin nx = P2X - BSZ; ndx = -1; end
      else if (m_bx + BSPD > SW - BSZ) begin m_scorer = 1; m_state = POINT; end
      else nx = m_bx + BSPD;
    end else begin
      if (m_bx - BSPD <= P1X + PW && overlaps(m_by, m_p1)) begin nx = P1X + PW; ndx = 1; end
      else if (m_bx < BSPD) begin m_scorer = 2; m_state = POINT; end
      else nx = m_bx - BSPD;
    end
    m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
  endtask

  task automatic model_award();
    int s;
    s = (m_scorer == 1) ? m_s1 : m_s2;
    s = (s < WIN) ? s + 1 : WIN;
    if (m_scorer == 1) m_s1 = s; else m_s2 = s;
    if (s == WIN) begin
      m_win = m_scorer; m_state = OVER;
    end else begin
      model_centre_ball();
      m_dx = (m_scorer == 1) ? 1 : -1;
      m_serve = 0; m_state = SERVE;
    end
  endtask

  // m_age counts the update cycles still owed to the last accepted tick.
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else if (m_age == 2) begin
      m_p1 = paddle_next(m_p1, p1_up, p1_dn);
      m_p2 = paddle_next(m_p2, p2_up, p2_dn);
      m_age = 1;
    end else if (m_age == 1) begin
      m_age = 0;
      if (m_state == SERVE) begin
        m_serve++;
        if (m_serve == SERVE_N) m_state = PLAY;
      end else model_ball();
    end else if (m_state == POINT) model_award();
    else if (start && (m_state == IDLE || m_state == OVER)) model_new_game();
    else if (frame_tick && (m_state == SERVE || m_state == PLAY)) m_age = 2;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (state == 3'(POINT)) seen_point = 1'b1;
      if (p1_y !== 10'(m_p1) || p2_y !== 10'(m_p2) || ball_x !== 10'(m_bx) ||
          ball_y !== 10'(m_by) || score_p1 !== 4'(m_s1) || score_p2 !== 4'(m_s2) ||
          state !== 3'(m_state) || winner !== 2'(m_win) || busy !== (m_age != 0)) begin
        errors++;
        $display("FAIL outputs t=%0t dut p1=%0d p2=%0d bx=%0d by=%0d sc=%0d/%0d st=%0d w=%0d busy=%0d model p1=%0d p2=%0d bx=%0d by=%0d sc=%0d/%0d st=%0d w=%0d busy=%0d",
                 $time, p1_y, p2_y, ball_x, ball_y, score_p1, score_p2, state, winner, busy,
                 m_p1, m_p2, m_bx, m_by, m_s1, m_s2, m_state, m_win, (m_age != 0));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (3) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  // mode 1 follows the ball, mode 2 runs away from it, 0 is idle; result is {up, dn}
  function automatic logic [1:0] ai(input int mode, input int py);
    int pc, bc;
    pc = py + PH / 2;
    bc = m_by + BSZ / 2;
    if (mode == 1) begin
      if (pc < bc - 2) return 2'b01;
      if (pc > bc + 2) return 2'b10;
      return 2'b00;
    end
    if (mode == 2) return (m_by < (SH - PH) / 2) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic drive_ai(input int mode1, input int mode2);
    {p1_up, p1_dn} = ai(mode1, m_p1);
    {p2_up, p2_dn} = ai(mode2, m_p2);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_p1_y", p1_y, 215);
    check("rst_p2_y", p2_y, 215);
    check("rst_ball_x", ball_x, 316);
    check("rst_ball_y", ball_y, 236);
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);

    tick();
    check("idle_ignores_tick", state, 0);
    pulse_start();
    check("start_to_serve", state, 1);

    // serve: hold-both, then p1 up / p2 down into the clamps
    p1_up = 1'b1; p1_dn = 1'b1;
    repeat (3) tick();
    check("p1_both_hold", p1_y, 215);
    p1_dn = 1'b0; p2_dn = 1'b1;
    for (int i = 4; i <= 60; i++) begin
      tick();
      if (i == 10) begin
        pulse_start();
        check("start_ignored_in_serve", state, 1);
      end
      if (i == 56) begin
        check("p1_y_at_3", p1_y, 3);
        check("p2_y_at_427", p2_y, 427);
      end
      if (i == 57) begin
        check("p1_y_clamp0", p1_y, 0);
        check("p2_y_clamp430", p2_y, 430);
      end
    end
    check("serve_to_play", state, 2);
    check("p1_y_stays0", p1_y, 0);
    check("serve_ball_x_held", ball_x, 316);
    p1_up = 1'b0; p2_dn = 1'b0;

    // first play frame, cycle by cycle
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("busy_cycle1", busy, 1);
    check("ball_x_not_yet_c1", ball_x, 316);
    step();
    check("busy_cycle2", busy, 1);
    check("ball_x_not_yet_c2", ball_x, 316);
    step();
    check("busy_done", busy, 0);
    check("first_ball_x", ball_x, 318);
    check("first_ball_y", ball_y, 238);
    step();

    // second frame: a tick re-issued while busy must be dropped
    frame_tick = 1'b1;
    step();
    step();
    frame_tick = 1'b0;
    repeat (3) step();
    check("tick_while_busy_dropped", ball_x, 320);

    // P2 tracks the ball, P1 runs away: bottom bounce, right-paddle hit, P2 point
    n = 2;
    while (m_s2 < 1 && n < 1500) begin
      drive_ai(2, 1);
      tick();
      n++;
      if (n == 119) check("bottom_clamp_y", ball_y, 473);
      if (n == 120) check("bottom_bounce_y", ball_y, 471);
      if (n == 154) check("p2_hit_x", ball_x, 623);
    end
    check("p2_scored", score_p2, 1);
    check("point_state_seen", seen_point, 1);
    check("after_point_serve", state, 1);
    check("recentre_x", ball_x, 316);
    check("recentre_y", ball_y, 236);

    repeat (60) begin drive_ai(1, 2); tick(); end
    drive_ai(1, 2);
    tick();
    check("serve_dir_left", ball_x, 314);

    // P1 tracks, P2 runs away: P1 points until the game is won
    n = 0;
    while (m_s1 < 1 && n < 1500) begin drive_ai(1, 2); tick(); n++; end
    check("p1_scored", score_p1, 1);
    check("p1_point_serve", state, 1);
    check("p1_point_recentre_x", ball_x, 316);
    repeat (60) begin drive_ai(1, 2); tick(); end
    drive_ai(1, 2);
    tick();
    check("serve_dir_right", ball_x, 318);

    n = 0;
    while (m_win == 0 && n < 8000) begin drive_ai(1, 2); tick(); n++; end
    check("final_score_p1", score_p1, 9);
    check("final_winner", winner, 1);
    check("final_state", state, 4);
    repeat (3) begin drive_ai(1, 1); tick(); end
    check("over_holds_state", state, 4);
    check("over_holds_score", score_p1, 9);

    // start and tick together in GAME_OVER: start wins, tick does not count
    {p1_up, p1_dn, p2_up, p2_dn} = 4'b0000;
    start = 1'b1; frame_tick = 1'b1;
    step();
    start = 1'b0; frame_tick = 1'b0;
    step();
    check("restart_state", state, 1);
    check("restart_score_p1", score_p1, 0);
    check("restart_winner", winner, 0);
    repeat (59) tick();
    check("tick_with_start_dropped", state, 1);
    tick();
    check("restart_play", state, 2);

    // reset mid-update
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    step();
    check("mr_p1_y", p1_y, 215);
    check("mr_p2_y", p2_y, 215);
    check("mr_ball_x", ball_x, 316);
    check("mr_ball_y", ball_y, 236);
    check("mr_score_p1", score_p1, 0);
    check("mr_winner", winner, 0);
    check("mr_state", state, 0);
    check("mr_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
